// File: rtl/flag_branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit_if
// Description : Bundles the EX-stage result, decode branch request and the
//               flag/branch outputs of flag_branch_unit.
//               master : the pipeline side, which drives EX/ID/flush.
//               slave  : flag_branch_unit, which returns flags, flag_we,
//                        br_taken, br_stall and br_redirect.
// Revision    : 1.0 - initial release
// ============================================================================
interface flag_branch_unit_if #(
    parameter int WIDTH = 16
);
    logic             ex_valid;
    logic             ex_stall;
    logic [3:0]       ex_opcode;
    logic [WIDTH-1:0] ex_result;
    logic             ex_ovfl;
    logic             id_branch;
    logic [2:0]       id_ccc;
    logic             flush;
    logic [2:0]       flags;        // {Z,V,N}
    logic             flag_we;
    logic             br_taken;
    logic             br_stall;
    logic             br_redirect;

    modport master (
        output ex_valid, ex_stall, ex_opcode, ex_result, ex_ovfl,
        output id_branch, id_ccc, flush,
        input  flags, flag_we, br_taken, br_stall, br_redirect
    );

    modport slave (
        input  ex_valid, ex_stall, ex_opcode, ex_result, ex_ovfl,
        input  id_branch, id_ccc, flush,
        output flags, flag_we, br_taken, br_stall, br_redirect
    );
endinterface
`default_nettype wire

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : Architectural Z/V/N flag register with per-opcode write masks
//               and branch-condition evaluation for the instruction in decode.
//               Produces a combinational br_taken, a registered br_redirect
//               toward fetch, and a flag-hazard stall.
// Ports       : clk, rst (synchronous, active high)
//               bus (slave) : ex_* EX result, id_* branch request, flush,
//                             flags {Z,V,N}, flag_we, br_taken, br_stall,
//                             br_redirect
// Config      : FLAG_BYPASS_EN - when defined, branches see the flag values
//               being written this cycle and br_stall is tied to 0; when
//               undefined, a branch depending on an in-flight flag write
//               stalls one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit #(
    parameter int WIDTH = 16
) (
    input  wire              clk,
    input  wire              rst,
    flag_branch_unit_if.slave bus
);
    localparam logic [2:0] c_CCC_ALWAYS = 3'b111;

    logic [2:0] r_flags;
    logic       r_redirect;

    logic       w_wr;
    logic       w_wr_z;     // opcode writes Z
    logic       w_wr_vn;    // opcode writes V and N
    logic [2:0] w_next_flags;
    logic [2:0] w_eff_flags;
    logic       w_cond;
    logic       w_stall;
    logic       w_taken;

    assign w_wr = bus.ex_valid & ~bus.ex_stall;

    always_comb begin
        w_wr_z  = 1'b0;
        w_wr_vn = 1'b0;
        case (bus.ex_opcode)
            4'b0000, 4'b0001: begin     // ADD, SUB
                w_wr_z  = 1'b1;
                w_wr_vn = 1'b1;
            end
            4'b0010, 4'b0100, 4'b0101, 4'b0110: begin  // XOR, SLL, SRA, ROR
                w_wr_z  = 1'b1;
            end
            default: ;
        endcase
    end

    // Every writing opcode writes Z, so Z's mask doubles as the write flag.
    assign bus.flag_we = w_wr & w_wr_z;

    always_comb begin
        w_next_flags = r_flags;
        if (bus.flag_we) begin
            w_next_flags[2] = (bus.ex_result == '0);
            if (w_wr_vn) begin
                w_next_flags[1] = bus.ex_ovfl;
                w_next_flags[0] = bus.ex_result[WIDTH-1];
            end
        end
    end

`ifdef FLAG_BYPASS_EN
    assign w_eff_flags = w_next_flags;
    assign w_stall     = 1'b0;
`else
    assign w_eff_flags = r_flags;
    assign w_stall     = bus.id_branch & bus.flag_we & (bus.id_ccc != c_CCC_ALWAYS);
`endif

    // w_eff_flags = {Z,V,N}
    always_comb begin
        w_cond = 1'b0;
        case (bus.id_ccc)
            3'b000:  w_cond = ~w_eff_flags[2];
            3'b001:  w_cond =  w_eff_flags[2];
            3'b010:  w_cond = ~w_eff_flags[2] & ~w_eff_flags[0];
            3'b011:  w_cond =  w_eff_flags[0];
            3'b100:  w_cond =  w_eff_flags[2] | ~w_eff_flags[0];
            3'b101:  w_cond =  w_eff_flags[0] |  w_eff_flags[2];
            3'b110:  w_cond =  w_eff_flags[1];
            default: w_cond = 1'b1;
        endcase
    end

    assign w_taken = bus.id_branch & w_cond & ~w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags    <= 3'b000;
            r_redirect <= 1'b0;
        end else begin
            r_flags    <= w_next_flags;
            r_redirect <= w_taken & ~bus.flush;
        end
    end

    assign bus.flags       = r_flags;
    assign bus.br_taken    = w_taken;
    assign bus.br_stall    = w_stall;
    assign bus.br_redirect = r_redirect;
endmodule
`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_branch_unit
// Description : Self-checking bench for flag_branch_unit. Combinational
//               outputs are compared mid-cycle; expected registered results
//               are queued when stimulus is applied and compared after the
//               following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_branch_unit;
    localparam int c_WIDTH = 16;

    typedef struct packed {
        logic [2:0] flags;
        logic       redir;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [2:0] m_flags;
    exp_t sb[$];

    flag_branch_unit_if #(.WIDTH(c_WIDTH)) bus ();

    flag_branch_unit #(.WIDTH(c_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Branch condition from the architectural table; f = {Z,V,N}.
    function automatic logic cond_of(input logic [2:0] f, input logic [2:0] ccc);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (ccc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // One clock cycle of stimulus. Inputs change 1 time unit after a rising
    // edge; combinational checks happen on the falling edge; registered
    // checks 1 unit after the next rising edge.
    task automatic step(input logic r, input logic valid, input logic stall,
                        input logic [3:0] op, input logic [15:0] res, input logic ovfl,
                        input logic br, input logic [2:0] ccc, input logic fl);
        logic       wr, we_exp, st_exp, tk_exp;
        logic [2:0] nf, eff;
        exp_t       e, got;
        rst           = r;
        bus.ex_valid  = valid;
        bus.ex_stall  = stall;
        bus.ex_opcode = op;
        bus.ex_result = res;
        bus.ex_ovfl   = ovfl;
        bus.id_branch = br;
        bus.id_ccc    = ccc;
        bus.flush     = fl;
        @(negedge clk);
        wr = valid && !stall;
        nf = m_flags;
        we_exp = 1'b0;
        if (wr && (op == 4'd0 || op == 4'd1)) begin
            we_exp = 1'b1;
            nf = {res == 16'h0, ovfl, res[15]};
        end else if (wr && (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6)) begin
            we_exp = 1'b1;
            nf[2] = (res == 16'h0);
        end
`ifdef FLAG_BYPASS_EN
        eff    = nf;
        st_exp = 1'b0;
`else
        eff    = m_flags;
        st_exp = br && we_exp && (ccc != 3'b111);
`endif
        tk_exp = br && cond_of(eff, ccc) && !st_exp;
        if (!r) begin
            chk("flags_cur", {13'd0, bus.flags}, {13'd0, m_flags});
            chk("flag_we",   {15'd0, bus.flag_we}, {15'd0, we_exp});
            chk("br_stall",  {15'd0, bus.br_stall}, {15'd0, st_exp});
            chk("br_taken",  {15'd0, bus.br_taken}, {15'd0, tk_exp});
        end
        e.flags = r ? 3'b000 : nf;
        e.redir = r ? 1'b0 : (tk_exp && !fl);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 16'd1, 16'd0);
        end else begin
            got = sb.pop_front();
            chk("flags_reg",   {13'd0, bus.flags}, {13'd0, got.flags});
            chk("br_redirect", {15'd0, bus.br_redirect}, {15'd0, got.redir});
            m_flags = got.flags;
        end
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 1'b0, 4'hF, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic ex(input logic [3:0] op, input logic [15:0] res, input logic ovfl);
        step(1'b0, 1'b1, 1'b0, op, res, ovfl, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_flags = 3'b000;
        @(posedge clk);
        #1;
        // Reset, with a flag-writing ADD presented while reset is still high.
        step(1'b1, 1'b0, 1'b0, 4'hF, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 16'h8000, 1'b1, 1'b1, 3'd7, 1'b0);
        chk("reset_flags", {13'd0, bus.flags}, 16'd0);
        chk("reset_redir", {15'd0, bus.br_redirect}, 16'd0);
        nop();

        // Masked writes.
        ex(4'h0, 16'h8000, 1'b1);                // ADD -> {0,1,1}
        chk("add_flags", {13'd0, bus.flags}, 16'h3);
        ex(4'h4, 16'h0000, 1'b0);                // SLL -> Z only -> {1,1,1}
        chk("sll_flags", {13'd0, bus.flags}, 16'h7);
        ex(4'hB, 16'h0000, 1'b0);                // LLB -> no write
        chk("llb_flags", {13'd0, bus.flags}, 16'h7);

        // Stall hold.
        ex(4'h0, 16'h0001, 1'b0);                // -> {0,0,0}
        step(1'b0, 1'b1, 1'b1, 4'h1, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("stall_hold", {13'd0, bus.flags}, 16'h0);
        ex(4'h1, 16'h0000, 1'b0);                // -> {1,0,0}
        chk("stall_release", {13'd0, bus.flags}, 16'h4);

        // Condition sweep across all flag combinations and condition codes.
        for (int f = 0; f < 8; f++) begin
            ex(4'h0, f[0] ? 16'h8000 : 16'h0001, f[1]);
            ex(4'h2, f[2] ? 16'h0000 : 16'h0001, 1'b0);
            chk("preload", {13'd0, bus.flags}, f[15:0]);
            for (int c = 0; c < 8; c++)
                step(1'b0, 1'b0, 1'b0, 4'hF, 16'h0, 1'b0, 1'b1, c[2:0], 1'b0);
        end

        // Flag hazard: EQ branch while SUB produces zero.
        ex(4'h0, 16'h0001, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h1, 16'h0, 1'b0, 1'b1, 3'd1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'hF, 16'h0, 1'b0, 1'b1, 3'd1, 1'b0);
        chk("hazard_followup_redir", {15'd0, bus.br_redirect}, 16'd1);
        // Same hazard with flush in cycle 0.
        ex(4'h0, 16'h0001, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h1, 16'h0, 1'b0, 1'b1, 3'd1, 1'b1);
        chk("flush_redir", {15'd0, bus.br_redirect}, 16'd0);
        // ALWAYS with a concurrent flag write never stalls.
        step(1'b0, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 3'd7, 1'b0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) != 0,
                 ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                 $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
Execute-stage neighbour directly downstream of the ALU shift/arith datapath. Consumes the 16-bit ALU result and overflow, and maintains the architectural Z/V/N flag register with per-opcode write masks. Evaluates the 3-bit branch condition for the instruction in decode and produces a registered redirect toward fetch, plus a flag-hazard stall when bypass is compiled out.

Parameters:
- WIDTH, 16: ALU result width. Z is computed from all WIDTH bits; N is taken from bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ex_valid  input  1  EX stage holds a real instruction
- ex_stall  input  1  EX held this cycle; no flag write
- ex_opcode  input  4  opcode of the EX instruction
- ex_result  input  WIDTH  ALU/shifter result
- ex_ovfl  input  1  signed overflow from the ADD/SUB path
- id_branch  input  1  decode holds B or BR
- id_ccc  input  3  branch condition code
- flush  input  1  squash the pending redirect
- flags  output  3  registered {Z,V,N}
- flag_we  output  1  flag write occurs this cycle (combinational)
- br_taken  output  1  condition true this cycle (combinational)
- br_stall  output  1  decode must hold (combinational; 0 when FLAG_BYPASS_EN is defined)
- br_redirect  output  1  registered br_taken, one cycle later

Behaviour:
- Reset: flags=3'b000, br_redirect=0. Reset mid-operation overrides any concurrent write.
- Write qualifier: wr = ex_valid & ~ex_stall.
- Opcode 0000 ADD and 0001 SUB: write Z, V and N.
- Opcodes 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: write Z only; V and N hold.
- All other opcodes (RED, PADDSB, LW, SW, LHB, LLB, B, BR, PCS, HLT): no write.
- flag_we = wr & (opcode in write set).
- Z = (ex_result == 0). N = ex_result[WIDTH-1]. V = ex_ovfl.
- Flags update at the rising edge following flag_we.
- Condition codes:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | (~Z & ~N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always: 1
- br_taken = id_branch & cond(eff_flags) & ~br_stall. eff_flags is defined under Optional Feature.
- br_redirect <= br_taken & ~flush. When flush and br_taken are both high, br_redirect=0 next cycle.
- ex_stall=1: flags hold even when ex_valid=1. A branch evaluated in that cycle uses the held flags.
- id_branch=0: br_taken=0 and br_stall=0 regardless of EX activity.
- ccc=111 never stalls and is always taken when id_branch=1.

Optional Feature:
Macro FLAG_BYPASS_EN.

Defined:
- eff_flags = next-state flags. Bits written by the current EX instruction are taken from that instruction; all other bits come from the register.
- br_stall is tied to 0.

Undefined:
- eff_flags = registered flags.
- br_stall = id_branch & flag_we & (ccc != 111); br_taken is forced 0 while br_stall=1.
- The following cycle re-evaluates against the updated register.

Test Plan:
- Reset check: assert rst, then issue a flag-writing instruction with rst still high. After release, flags=000 and br_redirect=0; the write had no effect.
- Masked write: ADD with result 16'h8000, ovfl=1, giving flags {0,1,1}. Then SLL with result 0 gives {1,1,1}, since V and N hold. Then LLB with result 0 gives no change.
- Stall hold: ex_stall=1 with SUB result 0. Flags unchanged and flag_we=0. Deassert stall the next cycle: Z=1.
- Condition sweep: preload each of the 8 flag combinations with id_branch=1 and all 8 ccc values. br_taken matches the condition table; br_redirect follows one cycle later.
- Hazard (bypass undefined): set Z=0, then issue SUB result 0 in EX with id_branch=1, ccc=001. Cycle 0: br_stall=1, br_taken=0. Cycle 1: br_taken=1.
- Same hazard with FLAG_BYPASS_EN defined: cycle 0 gives br_stall=0 and br_taken=1; br_redirect=1 in cycle 1. With flush=1 in cycle 0, br_redirect=0.
